// File: rtl/spi_word_receiver.sv
// SPI slave word receiver: deserialises one WORD_BITS frame per chip-select window.
// Latency: data_valid 3 clock_in cycles after the first edge sampling the final spi_clock_in low (5 with glitch filter).
// Backpressure: none; data_out is overwritten by each complete frame, pulses are single-cycle.
//
// Ports:
//   clock_in      system clock, all logic on its rising edge
//   reset         asynchronous active-low reset
//   spi_cs_in     chip select from master, active low, asynchronous
//   spi_clock_in  serial clock from master, idles high, asynchronous
//   spi_data_in   serial data, MSB first, sampled on spi_clock_in fall
//   data_out      last complete received word
//   data_valid    one-cycle pulse when data_out updates
//   frame_error   one-cycle pulse on a short frame or the first extra clock after a full word
//   busy          high from the accepted CS fall until the FSM is back in IDLE
//
// Optional feature: define SPI_RX_GLITCH_FILTER_EN to require three consecutive
// identical synchronized spi_clock_in samples before a clock level is accepted.
module spi_word_receiver #(
    parameter int WORD_BITS = 24
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 spi_cs_in,
    input  logic                 spi_clock_in,
    input  logic                 spi_data_in,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    // Counter must hold WORD_BITS itself, so it never wraps inside a frame.
    localparam int CNT_W = $clog2(WORD_BITS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        WAIT_CS   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. cs and clock idle high, so their stages reset
    // to 1; this keeps reset release from looking like a clock fall.
    // ------------------------------------------------------------------
    logic cs_s1, cs_s2, cs_prev;
    logic sck_s1, sck_s2, sck_prev;
    logic dat_s1, dat_s2;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_prev  <= 1'b1;
            sck_s1   <= 1'b1;
            sck_s2   <= 1'b1;
            sck_prev <= 1'b1;
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
        end else begin
            cs_s1    <= spi_cs_in;
            cs_s2    <= cs_s1;
            cs_prev  <= cs_s2;
            sck_s1   <= spi_clock_in;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            dat_s1   <= spi_data_in;
            dat_s2   <= dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // CS arming. The synchronizer resets to "high", so a CS that is
    // already low at reset release would otherwise appear as a fall.
    // A fall is only accepted once the synchronizer has flushed its
    // reset value and has then seen the real CS high at least once.
    // ------------------------------------------------------------------
    logic [1:0] settle;
    logic       cs_armed;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            settle   <= 2'b00;
            cs_armed <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            if (settle[1] && cs_s2) begin
                cs_armed <= 1'b1;
            end
        end
    end

    logic cs_fall;
    logic cs_rise;
    logic sck_fall;

    assign cs_fall = cs_armed & cs_prev & ~cs_s2;
    assign cs_rise = ~cs_prev & cs_s2;

`ifdef SPI_RX_GLITCH_FILTER_EN
    // Glitch filter: the accepted clock level only changes after three
    // consecutive identical synchronized samples. The fall is flagged in
    // the cycle the third low sample appears, while sck_flt still holds
    // the old high level, which keeps the added latency to two cycles.
    logic sck_prev2;
    logic sck_flt;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            sck_prev2 <= 1'b1;
            sck_flt   <= 1'b1;
        end else begin
            sck_prev2 <= sck_prev;
            if ((sck_s2 == sck_prev) && (sck_prev == sck_prev2)) begin
                sck_flt <= sck_s2;
            end
        end
    end

    assign sck_fall = sck_flt & ~sck_s2 & ~sck_prev & ~sck_prev2;
`else
    assign sck_fall = sck_prev & ~sck_s2;
`endif

    // ------------------------------------------------------------------
    // Event register stage. CS edges, the clock fall and its data bit are
    // registered together so the FSM sees coincident events in the same
    // cycle and can give the CS rise priority.
    // ------------------------------------------------------------------
    logic cs_fall_q, cs_rise_q, sck_fall_q, bit_q;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
            sck_fall_q <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            cs_fall_q  <= cs_fall;
            cs_rise_q  <= cs_rise;
            sck_fall_q <= sck_fall;
            bit_q      <= dat_s2;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] shift_in;
    logic [WORD_BITS-1:0] data_d;
    logic                 valid_d;
    logic                 err_d;
    logic                 extra_q, extra_d;  // extra-clock error already reported in this window

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            extra_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_out    <= data_d;
            data_valid  <= valid_d;
            frame_error <= err_d;
            extra_q     <= extra_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_out;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        extra_d  = extra_q;
        shift_in = {shift_q[WORD_BITS-2:0], bit_q};

        case (state_q)
            IDLE: begin
                // Clock edges with CS high are never looked at here.
                if (cs_fall_q) begin
                    state_d = RECEIVING;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end

            RECEIVING: begin
                if (cs_rise_q) begin
                    // CS rise wins over a coincident clock fall.
                    state_d = IDLE;
                    err_d   = (cnt_q < CNT_W'(WORD_BITS));
                end else if (sck_fall_q) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        data_d  = shift_in;
                        valid_d = 1'b1;
                        extra_d = 1'b0;
                        state_d = WAIT_CS;
                    end
                end
            end

            WAIT_CS: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                end else if (sck_fall_q && !extra_q) begin
                    // Only the first overrun clock in a window is reported.
                    err_d   = 1'b1;
                    extra_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_word_receiver.sv
// Self-checking bench for spi_word_receiver (WORD_BITS = 24).
// Table-driven frames plus hand-written reset/ignore/glitch sequences.
// A scoreboard queue holds expected data_valid / frame_error events.
module tb_spi_word_receiver;

    logic        clk;
    logic        rst_n;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_dat;
    logic [23:0] data_out;
    logic        data_valid;
    logic        frame_error;
    logic        busy;

    spi_word_receiver #(.WORD_BITS(24)) dut (
        .clock_in     (clk),
        .reset        (rst_n),
        .spi_cs_in    (spi_cs),
        .spi_clock_in (spi_sck),
        .spi_data_in  (spi_dat),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_error  (frame_error),
        .busy         (busy)
    );

`ifdef SPI_RX_GLITCH_FILTER_EN
    localparam int LAT = 6;  // cycle-counter delta from driving final fall to seeing data_valid
`else
    localparam int LAT = 4;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int last_fall_cyc = 0;

    typedef struct packed {
        logic        is_err;
        logic [23:0] dat;
    } ev_t;

    ev_t sb[$];
    ev_t ev;

    typedef struct {
        logic [23:0] word;
        int          nclk;
        bit          exp_valid;
        bit          exp_err;
        logic [23:0] exp_out;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cs_low;
        spi_cs = 1'b0;
        repeat (10) tick();
    endtask

    task automatic cs_high;
        repeat (5) tick();
        spi_cs = 1'b1;
        repeat (40) tick();  // two bit times of idle
    endtask

    // Clock n bits starting at bit index 'first'; bits past 23 carry 0.
    task automatic clock_bits(input logic [23:0] w, input int first, input int n, input int glitch_at);
        for (int i = first; i < first + n; i++) begin
            spi_dat = (i < 24) ? w[23 - i] : 1'b0;
            if (i == glitch_at) begin
                repeat (2) tick();
                spi_sck = 1'b0;
                tick();
                spi_sck = 1'b1;
                repeat (2) tick();
            end else begin
                repeat (5) tick();
            end
            spi_sck = 1'b0;
            if (i == 23) last_fall_cyc = cyc;
            repeat (10) tick();
            spi_sck = 1'b1;
            repeat (5) tick();
        end
    endtask

    // Scoreboard: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (data_valid || frame_error)) begin
            if (data_valid && frame_error) begin
                check("pulse_exclusive", 32'd1, 32'd0);
            end
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got valid=%0b err=%0b data=0x%0h, expected no event",
                         data_valid, frame_error, data_out);
            end else begin
                ev = sb.pop_front();
                check("event_kind", {31'd0, frame_error}, {31'd0, ev.is_err});
                check("event_data", {8'd0, data_out}, {8'd0, ev.dat});
                if (!ev.is_err) begin
                    check("valid_latency", cyc - last_fall_cyc, LAT);
                end
            end
        end
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{24'hA5C3F0, 24, 1'b1, 1'b0, 24'hA5C3F0};
        vecs[1] = '{24'h000001, 24, 1'b1, 1'b0, 24'h000001};
        vecs[2] = '{24'hFFFFFE, 24, 1'b1, 1'b0, 24'hFFFFFE};
        vecs[3] = '{24'h123456, 10, 1'b0, 1'b1, 24'hFFFFFE};
        vecs[4] = '{24'h654321, 24, 1'b1, 1'b0, 24'h654321};
        vecs[5] = '{24'hABCDEF, 26, 1'b1, 1'b1, 24'hABCDEF};

        rst_n   = 1'b0;
        spi_cs  = 1'b1;
        spi_sck = 1'b1;
        spi_dat = 1'b0;
        repeat (5) tick();
        check("rst_data_out", {8'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_error", {31'd0, frame_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (20) tick();

        // Clock activity with CS high must be ignored.
        for (int i = 0; i < 6; i++) begin
            spi_sck = 1'b0;
            repeat (10) tick();
            spi_sck = 1'b1;
            repeat (10) tick();
        end
        check("cs_high_busy", {31'd0, busy}, 32'd0);

        // Table-driven frames (back-to-back with two idle bits between).
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].exp_valid) sb.push_back('{1'b0, vecs[v].word});
            if (vecs[v].exp_err)   sb.push_back('{1'b1, vecs[v].exp_out});
            cs_low();
            if (v == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
            clock_bits(vecs[v].word, 0, vecs[v].nclk, -1);
            cs_high();
            check($sformatf("vec%0d_data_out", v), {8'd0, data_out}, {8'd0, vecs[v].exp_out});
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
        end

        // Reset at bit 12, released with CS still low: frame is aborted silently.
        cs_low();
        clock_bits(24'h0F0F0F, 0, 12, -1);
        rst_n = 1'b0;
        repeat (3) tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", {8'd0, data_out}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        clock_bits(24'h0F0F0F, 12, 12, -1);
        check("after_rst_busy", {31'd0, busy}, 32'd0);
        cs_high();
        check("after_rst_data_out", {8'd0, data_out}, 32'd0);

        sb.push_back('{1'b0, 24'h0F0F0F});
        cs_low();
        clock_bits(24'h0F0F0F, 0, 24, -1);
        cs_high();
        check("rst_recover_data_out", {8'd0, data_out}, 32'h0F0F0F);

`ifdef SPI_RX_GLITCH_FILTER_EN
        // One-cycle low glitch inside bit 5 must be rejected by the filter.
        sb.push_back('{1'b0, 24'h800001});
        cs_low();
        clock_bits(24'h800001, 0, 24, 5);
        cs_high();
        check("glitch_data_out", {8'd0, data_out}, 32'h800001);
`endif

        repeat (50) tick();
        check("pending_events", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_word_receiver.md
SPI_WORD_RECEIVER -- requirements
Module: spi_word_receiver

Interface
REQ-001 Parameter: WORD_BITS, default 24, number of bits per frame (range 8-32).
REQ-002 clock_in  input  1  system clock; all internal logic is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 spi_cs_in  input  1  chip select from the external master, active low, asynchronous to clock_in.
REQ-005 spi_clock_in  input  1  serial clock from the master; idles high, asynchronous.
REQ-006 spi_data_in  input  1  serial data, MSB first; changes on spi_clock_in rise, stable while low.
REQ-007 data_out  output  WORD_BITS  last complete received word.
REQ-008 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 frame_error  output  1  one-cycle pulse on a short frame or an overrun.
REQ-010 busy  output  1  high from the accepted CS fall until return to IDLE.

Function
REQ-011 spi_cs_in, spi_clock_in and spi_data_in SHALL each pass through a 2-flop synchronizer, plus a third "previous" register on cs and clock for edge detection.
REQ-012 The design SHALL support spi_clock_in low and high phases of at least 4 clock_in cycles each.
REQ-013 The state machine SHALL have three states: IDLE, RECEIVING and WAIT_CS.
REQ-014 IDLE -> RECEIVING on a detected CS fall: clear the bit counter and the shift register, and set busy.
REQ-015 In RECEIVING, each detected spi_clock_in fall SHALL shift in the synchronized data bit at the LSB and increment the bit counter.
REQ-016 On the WORD_BITS-th fall, the FSM SHALL load data_out with the full shift word, pulse data_valid for one cycle, and go to WAIT_CS.
REQ-017 data_valid SHALL assert exactly 3 clock_in cycles after the first clock_in edge that samples spi_clock_in low on the final bit.
REQ-018 A CS rise in RECEIVING with count < WORD_BITS SHALL pulse frame_error, leave data_out unchanged, and return to IDLE.
REQ-019 In WAIT_CS, the first extra spi_clock_in fall SHALL pulse frame_error; further extra falls are ignored; data_out is unchanged.
REQ-020 A CS rise in WAIT_CS SHALL return to IDLE with busy low and no pulse.
REQ-021 When a CS rise and a clock fall are detected in the same cycle, the CS rise SHALL take priority and the clock edge SHALL be discarded.
REQ-022 spi_clock_in edges while CS is high SHALL be ignored.
REQ-023 A CS fall already synchronized low at reset release SHALL NOT start a frame; only a detected high-to-low transition does.
REQ-024 data_valid and frame_error SHALL never be high in the same cycle.
REQ-025 The bit counter SHALL be wide enough to hold WORD_BITS and SHALL NOT wrap within a frame.

Reset
REQ-026 While reset = 0, the block SHALL force: state IDLE; data_out 0; data_valid 0; frame_error 0; busy 0; counter and shift register 0.
REQ-027 While reset = 0, the synchronizers SHALL force cs and clock stages to 1 and data stages to 0.
REQ-028 Reset asserted mid-frame SHALL abort that frame with no data_valid and no frame_error pulse.

Configuration
REQ-029 With macro SPI_RX_GLITCH_FILTER_EN defined, spi_clock_in SHALL be accepted only after 3 consecutive identical synchronized samples; pulses shorter than 3 cycles are rejected.
REQ-030 With the filter enabled, the REQ-017 latency SHALL become 5 cycles and the minimum phase from REQ-012 SHALL become 6 cycles.
REQ-031 Without SPI_RX_GLITCH_FILTER_EN, the filter logic SHALL be absent and REQ-012/REQ-017 hold as written.

Verification
REQ-032 Bench: a 24-bit frame 0xA5C3F0 at 20 clock_in per bit -> one data_valid pulse, data_out = 0xA5C3F0, frame_error stays 0, busy low after CS rise.
REQ-033 Bench: back-to-back frames 0x000001 then 0xFFFFFE with 2 idle bits between -> two data_valid pulses with the correct words in order.
REQ-034 Bench: CS rise after 10 bits of 0x123456 -> one frame_error pulse; data_out keeps the prior value; a following full frame 0x654321 is received correctly.
REQ-035 Bench: 26 clocks within one CS window carrying 0xABCDEF -> data_valid with 0xABCDEF, then exactly one frame_error pulse.
REQ-036 Bench: reset asserted at bit 12 and released mid-frame -> no pulses; the next full frame 0x0F0F0F is received correctly.
REQ-037 Bench (filter on): a 1-cycle low glitch on spi_clock_in during bit 5 of 0x800001 -> data_out = 0x800001 with no frame_error.
